// File: rtl/cpu7_csr_exc.sv
// Privileged CSR file for cpu7: software CSR access, exception entry/ERTN, constant timer, interrupt sampling.
// Latency: reads combinational (no write bypass); writes/exc/ertn apply at next edge; int_pending one cycle behind.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Ports: clk/resetn (async active-low); csr_raddr/csr_rdata read port; csr_waddr/csr_wdata/csr_wen
// write port; exc_valid/exc_ecode/exc_pc exception commit; ertn_valid ERTN commit; hw_int level
// interrupt lines; csr_eentry/csr_era/csr_plv/csr_ie/int_pending state exported to the pipeline.
module cpu7_csr_exc #(
    parameter int GRLEN      = 32,
    parameter int CSR_BIT    = 14,
    parameter int TIMER_BITS = 32,
    parameter int N_SAVE     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [CSR_BIT-1:0] csr_raddr,
    output logic [GRLEN-1:0]   csr_rdata,
    input  logic [CSR_BIT-1:0] csr_waddr,
    input  logic [GRLEN-1:0]   csr_wdata,
    input  logic               csr_wen,
    input  logic               exc_valid,
    input  logic [5:0]         exc_ecode,
    input  logic [GRLEN-1:0]   exc_pc,
    input  logic               ertn_valid,
    input  logic [7:0]         hw_int,
    output logic [GRLEN-1:0]   csr_eentry,
    output logic [GRLEN-1:0]   csr_era,
    output logic [1:0]         csr_plv,
    output logic               csr_ie,
    output logic               int_pending
);

    localparam logic [CSR_BIT-1:0] A_CRMD   = 'h00;
    localparam logic [CSR_BIT-1:0] A_PRMD   = 'h01;
    localparam logic [CSR_BIT-1:0] A_ECFG   = 'h04;
    localparam logic [CSR_BIT-1:0] A_ESTAT  = 'h05;
    localparam logic [CSR_BIT-1:0] A_ERA    = 'h06;
    localparam logic [CSR_BIT-1:0] A_EENTRY = 'h0C;
    localparam logic [CSR_BIT-1:0] A_SAVE0  = 'h30;
    localparam logic [CSR_BIT-1:0] A_TID    = 'h40;
    localparam logic [CSR_BIT-1:0] A_TCFG   = 'h41;
    localparam logic [CSR_BIT-1:0] A_TVAL   = 'h42;
    localparam logic [CSR_BIT-1:0] A_TICLR  = 'h44;

    logic [1:0]             crmd_plv, prmd_pplv;
    logic                   crmd_ie, prmd_pie;
    logic [12:0]            ecfg_lie;
    logic [1:0]             is_sw;
    logic [7:0]             is_hw;
    logic                   is_ti;
    logic [5:0]             estat_ecode;
    logic [GRLEN-1:0]       era;
    logic [GRLEN-1:6]       eentry_hi;
    logic [GRLEN-1:0]       save_q [N_SAVE];
    logic [GRLEN-1:0]       tid;
    logic [TIMER_BITS-1:0]  tcfg;
    logic [TIMER_BITS-1:0]  tval;

    logic [12:0]            is_vec;
    logic                   wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_eentry;
    logic                   wr_tid, wr_tcfg, wr_ticlr;
    logic                   timer_expire;
    logic [TIMER_BITS-1:0]  reload_cur, reload_new;

    // IS[10] and IS[12] have no source in this core and read as 0.
    assign is_vec = {1'b0, is_ti, 1'b0, is_hw, is_sw};

    assign wr_crmd   = csr_wen && (csr_waddr == A_CRMD);
    assign wr_prmd   = csr_wen && (csr_waddr == A_PRMD);
    assign wr_ecfg   = csr_wen && (csr_waddr == A_ECFG);
    assign wr_estat  = csr_wen && (csr_waddr == A_ESTAT);
    assign wr_era    = csr_wen && (csr_waddr == A_ERA);
    assign wr_eentry = csr_wen && (csr_waddr == A_EENTRY);
    assign wr_tid    = csr_wen && (csr_waddr == A_TID);
    assign wr_tcfg   = csr_wen && (csr_waddr == A_TCFG);
    assign wr_ticlr  = csr_wen && (csr_waddr == A_TICLR);

    assign reload_cur = {tcfg[TIMER_BITS-1:2], 2'b00};
    assign reload_new = {csr_wdata[TIMER_BITS-1:2], 2'b00};

    // A TCFG write on the expiry cycle reloads TVAL and suppresses that expiry.
    assign timer_expire = !wr_tcfg && tcfg[0] && (tval == TIMER_BITS'(1));

    assign csr_eentry = {eentry_hi, 6'b0};
    assign csr_era    = era;
    assign csr_plv    = crmd_plv;
    assign csr_ie     = crmd_ie;

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            A_CRMD:   csr_rdata[2:0] = {crmd_ie, crmd_plv};
            A_PRMD:   csr_rdata[2:0] = {prmd_pie, prmd_pplv};
            A_ECFG:   csr_rdata[12:0] = ecfg_lie;
            A_ESTAT: begin
                csr_rdata[12:0]  = is_vec;
                csr_rdata[21:16] = estat_ecode;
            end
            A_ERA:    csr_rdata = era;
            A_EENTRY: csr_rdata = {eentry_hi, 6'b0};
            A_TID:    csr_rdata = tid;
            A_TCFG:   csr_rdata[TIMER_BITS-1:0] = tcfg;
            A_TVAL:   csr_rdata[TIMER_BITS-1:0] = tval;
            default:  ;
        endcase
        for (int k = 0; k < N_SAVE; k++) begin
            if (csr_raddr == A_SAVE0 + CSR_BIT'(k)) csr_rdata = save_q[k];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_plv    <= '0;
            crmd_ie     <= 1'b0;
            prmd_pplv   <= '0;
            prmd_pie    <= 1'b0;
            ecfg_lie    <= '0;
            is_sw       <= '0;
            is_hw       <= '0;
            is_ti       <= 1'b0;
            estat_ecode <= '0;
            era         <= '0;
            eentry_hi   <= '0;
            for (int k = 0; k < N_SAVE; k++) save_q[k] <= '0;
            tid         <= '0;
            tcfg        <= '0;
            tval        <= '0;
            int_pending <= 1'b0;
        end else begin
            // Per-field priority: exception entry, then ERTN, then software write.
            if (exc_valid) begin
                crmd_plv <= 2'b00;
                crmd_ie  <= 1'b0;
            end else if (ertn_valid) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end else if (wr_crmd) begin
                crmd_plv <= csr_wdata[1:0];
                crmd_ie  <= csr_wdata[2];
            end

            if (exc_valid) begin
                prmd_pplv <= crmd_plv;
                prmd_pie  <= crmd_ie;
            end else if (wr_prmd) begin
                prmd_pplv <= csr_wdata[1:0];
                prmd_pie  <= csr_wdata[2];
            end

            if (exc_valid) begin
                era         <= exc_pc;
                estat_ecode <= exc_ecode;
            end else if (wr_era) begin
                era <= csr_wdata;
            end

            if (wr_ecfg)   ecfg_lie  <= csr_wdata[12:0] & ~13'h0400;
            if (wr_estat)  is_sw     <= csr_wdata[1:0];
            if (wr_eentry) eentry_hi <= csr_wdata[GRLEN-1:6];
            if (wr_tid)    tid       <= csr_wdata;
            for (int k = 0; k < N_SAVE; k++) begin
                if (csr_wen && (csr_waddr == A_SAVE0 + CSR_BIT'(k))) save_q[k] <= csr_wdata;
            end

            is_hw <= hw_int;

            // Expiry beats a simultaneous TICLR clear.
            if (timer_expire)                  is_ti <= 1'b1;
            else if (wr_ticlr && csr_wdata[0]) is_ti <= 1'b0;

            if (wr_tcfg) begin
                tcfg <= csr_wdata[TIMER_BITS-1:0];
                tval <= reload_new;
            end else if (tcfg[0] && (tval != '0)) begin
                if (tval == TIMER_BITS'(1)) tval <= tcfg[1] ? reload_cur : '0;
                else                        tval <= tval - TIMER_BITS'(1);
            end

            int_pending <= crmd_ie & (|(is_vec & ecfg_lie));
        end
    end

endmodule

// File: tb/tb_cpu7_csr_exc.sv
module tb_cpu7_csr_exc;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [13:0] csr_raddr = '0;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_wen = 1'b0;
    logic        exc_valid = 1'b0;
    logic [5:0]  exc_ecode = '0;
    logic [31:0] exc_pc = '0;
    logic        ertn_valid = 1'b0;
    logic [7:0]  hw_int = '0;
    logic [31:0] csr_eentry, csr_era;
    logic [1:0]  csr_plv;
    logic        csr_ie, int_pending;

    int n_cmp = 0;
    int n_bad = 0;

    cpu7_csr_exc #(.GRLEN(32), .CSR_BIT(14), .TIMER_BITS(32), .N_SAVE(4)) dut (
        .clk(clk), .resetn(resetn),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
        .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_pc(exc_pc),
        .ertn_valid(ertn_valid), .hw_int(hw_int),
        .csr_eentry(csr_eentry), .csr_era(csr_era), .csr_plv(csr_plv),
        .csr_ie(csr_ie), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    // Reference model: each CSR held as its software-visible 32-bit image.
    typedef struct packed {
        logic [31:0]       crmd, prmd, ecfg, estat, era, eentry, tid, tcfg, tval;
        logic [3:0][31:0]  save;
        logic              ip;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n = s;
        logic tcfg_wr = csr_wen && (csr_waddr == 14'h41);
        logic expired = 1'b0;
        if (csr_wen) begin
            case (csr_waddr)
                14'h00: n.crmd   = csr_wdata & 32'h7;
                14'h01: n.prmd   = csr_wdata & 32'h7;
                14'h04: n.ecfg   = csr_wdata & 32'h1BFF;
                14'h05: n.estat  = (s.estat & ~32'h3) | (csr_wdata & 32'h3);
                14'h06: n.era    = csr_wdata;
                14'h0C: n.eentry = csr_wdata & ~32'h3F;
                14'h30, 14'h31, 14'h32, 14'h33: n.save[csr_waddr[1:0]] = csr_wdata;
                14'h40: n.tid    = csr_wdata;
                14'h41: begin
                    n.tcfg = csr_wdata;
                    n.tval = csr_wdata & ~32'h3;
                end
                default: ;
            endcase
        end
        if (!tcfg_wr && s.tcfg[0] && s.tval != 32'd0) begin
            n.tval = s.tval - 32'd1;
            if (n.tval == 32'd0) begin
                expired = 1'b1;
                if (s.tcfg[1]) n.tval = s.tcfg & ~32'h3;
            end
        end
        if (csr_wen && csr_waddr == 14'h44 && csr_wdata[0]) n.estat[11] = 1'b0;
        if (expired) n.estat[11] = 1'b1;
        n.estat[9:2] = hw_int;
        // Later assignments override earlier ones: exception > ERTN > software write.
        if (ertn_valid) n.crmd = s.prmd;
        if (exc_valid) begin
            n.prmd = s.crmd;
            n.crmd = 32'd0;
            n.era  = exc_pc;
            n.estat[21:16] = exc_ecode;
        end
        n.ip = s.crmd[2] && ((s.estat & s.ecfg & 32'h1FFF) != 32'd0);
        return n;
    endfunction

    function automatic logic [31:0] model_rd(input logic [13:0] a);
        case (a)
            14'h00: return m.crmd;
            14'h01: return m.prmd;
            14'h04: return m.ecfg;
            14'h05: return m.estat;
            14'h06: return m.era;
            14'h0C: return m.eentry;
            14'h30, 14'h31, 14'h32, 14'h33: return m.save[a[1:0]];
            14'h40: return m.tid;
            14'h41: return m.tcfg;
            14'h42: return m.tval;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= '0;
        else         m <= model_next(m);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mchk();
        check("plv_vs_model", 32'(csr_plv), m.crmd & 32'h3);
        check("ie_vs_model", 32'(csr_ie), 32'(m.crmd[2]));
        check("era_vs_model", csr_era, m.era);
        check("eentry_vs_model", csr_eentry, m.eentry);
        check("intp_vs_model", 32'(int_pending), 32'(m.ip));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        csr_wen = 1'b0; exc_valid = 1'b0; ertn_valid = 1'b0; csr_wdata = '0;
        mchk();
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
        step();
    endtask

    task automatic rdchk(input string tag, input logic [13:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic is11chk(input string tag, input logic exp);
        logic [31:0] v;
        csr_raddr = 14'h05;
        #1;
        v = csr_rdata;
        check(tag, 32'(v[11]), 32'(exp));
    endtask

    function automatic logic [31:0] periodic_tval(input int i);
        return (i % 8 == 0) ? 32'd8 : 32'(8 - (i % 8));
    endfunction

    logic [13:0] alist [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        alist = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0C, 14'h30, 14'h31,
                  14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02, 14'h34};

        // Reset: every address reads 0, every output 0.
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) rdchk("reset_rd", alist[i], 32'd0);
        check("reset_eentry", csr_eentry, 32'd0);
        check("reset_era", csr_era, 32'd0);
        check("reset_plv", 32'(csr_plv), 32'd0);
        check("reset_ie", 32'(csr_ie), 32'd0);
        check("reset_intp", 32'(int_pending), 32'd0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;

        // Exception entry and ERTN.
        wr(14'h00, 32'h7);
        check("crmd_plv", 32'(csr_plv), 32'd3);
        exc_valid = 1'b1; exc_ecode = 6'h0B; exc_pc = 32'h1C000100;
        step();
        rdchk("exc_crmd", 14'h00, 32'h0);
        rdchk("exc_prmd", 14'h01, 32'h7);
        rdchk("exc_estat", 14'h05, 32'h000B0000);
        check("exc_era", csr_era, 32'h1C000100);
        ertn_valid = 1'b1;
        step();
        rdchk("ertn_crmd", 14'h00, 32'h7);
        rdchk("ertn_prmd", 14'h01, 32'h7);

        // exc + ertn + CRMD write in one cycle: exception wins.
        wr(14'h00, 32'h5);
        exc_valid = 1'b1; ertn_valid = 1'b1;
        wr(14'h00, 32'h3);
        rdchk("prio_crmd", 14'h00, 32'h0);
        rdchk("prio_prmd", 14'h01, 32'h5);
        ertn_valid = 1'b1;
        step();
        rdchk("prio_ertn_crmd", 14'h00, 32'h5);

        wr(14'h0C, 32'hFFFFFFFF);
        check("eentry_mask", csr_eentry, 32'hFFFFFFC0);
        wr(14'h04, 32'hFFFFFFFF);
        rdchk("ecfg_mask", 14'h04, 32'h1BFF);

        // One-shot timer, InitVal=4.
        wr(14'h04, 32'h800);
        wr(14'h41, 32'h11);
        rdchk("os_load", 14'h42, 32'd16);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) begin
                rdchk("os_tval15", 14'h42, 32'd1);
                is11chk("os_is11_early", 1'b0);
            end
            if (i == 16) begin
                rdchk("os_tval16", 14'h42, 32'd0);
                is11chk("os_is11_set", 1'b1);
                check("os_intp_lag", 32'(int_pending), 32'd0);
            end
        end
        step();
        check("os_intp", 32'(int_pending), 32'd1);
        rdchk("os_hold", 14'h42, 32'd0);
        wr(14'h44, 32'h1);
        rdchk("ticlr_rd", 14'h44, 32'd0);
        is11chk("os_ticlr", 1'b0);
        step();
        check("os_intp_clr", 32'(int_pending), 32'd0);

        // Periodic timer, InitVal=2.
        wr(14'h41, 32'h0B);
        rdchk("per_load", 14'h42, 32'd8);
        for (int i = 1; i <= 8; i++) begin
            step();
            rdchk("per_tval", 14'h42, periodic_tval(i));
        end
        is11chk("per_is11", 1'b1);
        wr(14'h44, 32'h1);
        rdchk("per_tval9", 14'h42, periodic_tval(9));
        is11chk("per_clr", 1'b0);
        for (int i = 10; i <= 15; i++) begin
            step();
            rdchk("per_tval", 14'h42, periodic_tval(i));
        end
        wr(14'h44, 32'h1);
        rdchk("per_tval16", 14'h42, periodic_tval(16));
        is11chk("per_set_beats_clr", 1'b1);
        wr(14'h44, 32'h1);
        for (int i = 18; i <= 23; i++) step();
        rdchk("per_tval23", 14'h42, 32'd1);
        wr(14'h41, 32'h0F);
        rdchk("tcfg_beats_expiry", 14'h42, 32'd12);
        is11chk("tcfg_no_set", 1'b0);
        repeat (11) step();
        rdchk("per3_tval1", 14'h42, 32'd1);
        wr(14'h05, 32'hFFFFFFFF);
        rdchk("estat_wr_expiry", 14'h05, 32'h000B0803);
        rdchk("per3_reload", 14'h42, 32'd12);
        wr(14'h41, 32'h0);
        wr(14'h05, 32'h0);
        wr(14'h44, 32'h1);

        // InitVal=0 with En=1 never expires.
        wr(14'h41, 32'h1);
        repeat (5) step();
        rdchk("iv0_tval", 14'h42, 32'd0);
        is11chk("iv0_is11", 1'b0);
        wr(14'h41, 32'h0);

        // Hardware interrupt sampling.
        wr(14'h04, 32'h200);
        step();
        step();
        hw_int = 8'h80;
        step();
        csr_raddr = 14'h05; #1; v = csr_rdata;
        check("hw_is9", v & 32'h1FFF, 32'h200);
        check("hw_intp_lag", 32'(int_pending), 32'd0);
        step();
        check("hw_intp", 32'(int_pending), 32'd1);
        hw_int = 8'h00;
        step();
        csr_raddr = 14'h05; #1; v = csr_rdata;
        check("hw_is9_drop", v & 32'h1FFF, 32'h0);
        check("hw_intp_hold", 32'(int_pending), 32'd1);
        step();
        check("hw_intp_drop", 32'(int_pending), 32'd0);
        wr(14'h05, 32'h3FC);
        csr_raddr = 14'h05; #1; v = csr_rdata;
        check("estat_ro_is", v & 32'h1FFF, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [13:0] a;
            a = alist[$urandom_range(0, 15)];
            csr_wen   = ($urandom_range(0, 2) == 0);
            csr_waddr = a;
            csr_wdata = (a == 14'h41) ? 32'($urandom_range(0, 63)) : $urandom;
            exc_valid  = ($urandom_range(0, 15) == 0);
            ertn_valid = ($urandom_range(0, 15) == 0);
            exc_ecode  = 6'($urandom_range(0, 63));
            exc_pc     = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
            step();
            for (int r = 0; r < 2; r++) begin
                csr_raddr = alist[$urandom_range(0, 15)];
                #1;
                check("rand_rd", csr_rdata, model_rd(csr_raddr));
            end
        end

        // Asynchronous reset mid-countdown.
        hw_int = 8'h00;
        wr(14'h41, 32'h41);
        repeat (5) step();
        #2 resetn = 1'b0;
        rdchk("areset_tval", 14'h42, 32'd0);
        rdchk("areset_estat", 14'h05, 32'd0);
        rdchk("areset_tcfg", 14'h41, 32'd0);
        check("areset_era", csr_era, 32'd0);
        check("areset_intp", 32'(int_pending), 32'd0);
        @(negedge clk) resetn = 1'b1;
        step();
        rdchk("post_reset_tval", 14'h42, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
